// File: rtl/aib_rxfifo_rd_pkg.sv
// Shared types and helpers for the AIB RX FIFO read-side controller.
// Holds the FIFO mode and FSM state encodings, the lane count per entry,
// and the binary/Gray pointer conversions.
package aib_rxfifo_rd_pkg;

   typedef enum logic [1:0] {
      FIFO_1X  = 2'b00,
      FIFO_2X  = 2'b01,
      FIFO_4X  = 2'b10,
      FIFO_REG = 2'b11
   } fifo_mode_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      RUN  = 2'd2
   } rd_state_e;

   localparam int LANES_PER_ENTRY = 4;

   // Register mode drives all four lanes of entry 0.
   localparam logic [LANES_PER_ENTRY-1:0] REG_LANES = 4'hF;

   // Widest pointer the conversion helpers handle; callers size-cast.
   localparam int PTR_MAX_W = 32;

   function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
      logic [PTR_MAX_W-1:0] b;
      b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
      for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/aib_rxfifo_rd_lanesel.sv
// Combinational lane-select decoder: turns the entry being popped, the FIFO
// mode and Gen2 into the one-hot-per-lane read-enable mask. The parent
// registers the result.
module aib_rxfifo_rd_lanesel
   import aib_rxfifo_rd_pkg::*;
#(
   parameter  int DEPTH  = 16,
   parameter  int PTRW   = $clog2(DEPTH),
   localparam int DEPTH4 = DEPTH * LANES_PER_ENTRY
) (
   input  logic [PTRW-1:0]   entry,
   input  fifo_mode_e        mode,
   input  logic              gen2,
   input  logic              pop,
   output logic [DEPTH4-1:0] mask
);

   logic [LANES_PER_ENTRY-1:0] lanes;
   logic [PTRW-1:0]            slot;

   // Pick the lane pattern for the mode, then shift it to the entry's slot.
   always_comb begin
      lanes = '0;
      slot  = entry;
      case (mode)
         FIFO_1X: lanes = 4'b0001;
         FIFO_2X: lanes = 4'b0011;
         // 4:1 without Gen2 is not legal on the link; fall back to 2 lanes.
         FIFO_4X: lanes = gen2 ? 4'b1111 : 4'b0011;
         default: begin
            lanes = REG_LANES;
            slot  = '0;
         end
      endcase
      mask = pop ? (DEPTH4'(lanes) << {slot, 2'b00}) : '0;
   end

endmodule

// File: rtl/aib_rxfifo_rd_ctrl.sv
// Read-side controller for the AIB RX adapter FIFO (rd_clk domain).
// Owns the read pointer, the watermark start-up (IDLE -> FILL -> RUN),
// empty/underflow detection and the registered per-lane read enables.
// Latency: pop in cycle c -> fifo_rd_en in c+1 -> rd_valid in c+2.
// Build option AIB_RXFIFO_RD_GRAY_EN: rd_ptr leaves Gray-coded from its own
// register and wr_ptr_sync is taken as Gray; otherwise both are binary.
module aib_rxfifo_rd_ctrl
   import aib_rxfifo_rd_pkg::*;
#(
   parameter  int DEPTH  = 16,
   parameter  int PTRW   = $clog2(DEPTH),
   localparam int DEPTH4 = DEPTH * LANES_PER_ENTRY
) (
   input  logic              rd_clk,
   input  logic              rd_rst,
   input  logic              rd_start,
   input  logic [1:0]        r_fifo_mode,
   input  logic              m_gen2_mode,
   input  logic [PTRW:0]     r_rd_wm,
   input  logic              rd_req,
   input  logic [PTRW:0]     wr_ptr_sync,
   output logic [DEPTH4-1:0] fifo_rd_en,
   output logic [PTRW:0]     rd_ptr,
   output logic              rd_valid,
   output logic              fifo_empty,
   output logic              rd_underflow,
   output logic [1:0]        rd_state
);

   fifo_mode_e        mode;
   rd_state_e         state;
   logic [PTRW:0]     rd_bin;
   logic [PTRW:0]     rd_bin_inc;
   logic [PTRW:0]     wr_bin;
   logic [PTRW:0]     lvl;
   logic              pop;
   logic              underflow_set;
   logic              vld_p1;
   logic [DEPTH4-1:0] lane_mask;

   assign mode       = fifo_mode_e'(r_fifo_mode);
   assign rd_bin_inc = rd_bin + 1'b1;

`ifdef AIB_RXFIFO_RD_GRAY_EN
   logic [PTRW:0] rd_gray;

   assign wr_bin = (PTRW+1)'(gray2bin(PTR_MAX_W'(wr_ptr_sync)));
   assign rd_ptr = rd_gray;
`else
   assign wr_bin = wr_ptr_sync;
   assign rd_ptr = rd_bin;
`endif

   // Fill level relies on modulo wrap of the extra pointer bit.
   assign lvl        = wr_bin - rd_bin;
   assign fifo_empty = (lvl == '0);

   assign pop           = (state == RUN) && rd_req && !fifo_empty && (mode != FIFO_REG);
   assign underflow_set = (state == RUN) && rd_req &&  fifo_empty && (mode != FIFO_REG);
   assign rd_state      = state;

   aib_rxfifo_rd_lanesel #(
      .DEPTH (DEPTH),
      .PTRW  (PTRW)
   ) u_lanesel (
      .entry (rd_bin[PTRW-1:0]),
      .mode  (mode),
      .gen2  (m_gen2_mode),
      .pop   (pop),
      .mask  (lane_mask)
   );

   // FSM, read pointer and the enable/valid pipeline; dropping rd_start
   // returns everything to the IDLE values.
   always_ff @(posedge rd_clk or posedge rd_rst) begin
      if (rd_rst) begin
         state        <= IDLE;
         rd_bin       <= '0;
`ifdef AIB_RXFIFO_RD_GRAY_EN
         rd_gray      <= '0;
`endif
         fifo_rd_en   <= '0;
         vld_p1       <= 1'b0;
         rd_valid     <= 1'b0;
         rd_underflow <= 1'b0;
      end else if (!rd_start) begin
         state        <= IDLE;
         rd_bin       <= '0;
`ifdef AIB_RXFIFO_RD_GRAY_EN
         rd_gray      <= '0;
`endif
         fifo_rd_en   <= '0;
         vld_p1       <= 1'b0;
         rd_valid     <= 1'b0;
         rd_underflow <= 1'b0;
      end else begin
         // stage p1: lane enables of the popped entry
         fifo_rd_en <= lane_mask;
         vld_p1     <= pop;
         // stage p2: datapath output valid
         rd_valid   <= vld_p1;

         if (pop) begin
            rd_bin  <= rd_bin_inc;
`ifdef AIB_RXFIFO_RD_GRAY_EN
            rd_gray <= (PTRW+1)'(bin2gray(PTR_MAX_W'(rd_bin_inc)));
`endif
         end

         if (underflow_set) begin
            rd_underflow <= 1'b1;
         end

         case (state)
            IDLE: begin
               if (mode == FIFO_REG) begin
                  state      <= RUN;
                  fifo_rd_en <= DEPTH4'(REG_LANES);
                  vld_p1     <= 1'b1;
               end else begin
                  state <= FILL;
               end
            end
            FILL: begin
               if (lvl >= r_rd_wm) begin
                  state <= RUN;
               end
            end
            RUN: begin
               // Register mode streams entry 0 continuously.
               if (mode == FIFO_REG) begin
                  fifo_rd_en <= DEPTH4'(REG_LANES);
                  vld_p1     <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_aib_rxfifo_rd_ctrl.sv
// Self-checking bench for aib_rxfifo_rd_ctrl. A behavioural model counts
// words read and written and derives the expected outputs from those counts.
module tb_aib_rxfifo_rd_ctrl;

   localparam int DEPTH  = 16;
   localparam int PTRW   = 4;
   localparam int DEPTH4 = DEPTH * 4;
   localparam int PMOD   = 2 * DEPTH;
   localparam int VW     = DEPTH4 + PTRW + 6;

   logic              clk = 1'b0;
   logic              rst;
   logic              rd_start;
   logic [1:0]        r_fifo_mode;
   logic              m_gen2_mode;
   logic [PTRW:0]     r_rd_wm;
   logic              rd_req;
   logic [PTRW:0]     wr_ptr_sync;
   logic [DEPTH4-1:0] fifo_rd_en;
   logic [PTRW:0]     rd_ptr;
   logic              rd_valid;
   logic              fifo_empty;
   logic              rd_underflow;
   logic [1:0]        rd_state;

   int wr_cnt;
   int nchk;
   int nerr;

   // model state
   int                m_phase;
   int                m_reads;
   logic [DEPTH4-1:0] m_en;
   logic              m_v1;
   logic              m_valid;
   logic              m_uf;

   always #5 clk = ~clk;

   aib_rxfifo_rd_ctrl #(.DEPTH(DEPTH)) dut (
      .rd_clk       (clk),
      .rd_rst       (rst),
      .rd_start     (rd_start),
      .r_fifo_mode  (r_fifo_mode),
      .m_gen2_mode  (m_gen2_mode),
      .r_rd_wm      (r_rd_wm),
      .rd_req       (rd_req),
      .wr_ptr_sync  (wr_ptr_sync),
      .fifo_rd_en   (fifo_rd_en),
      .rd_ptr       (rd_ptr),
      .rd_valid     (rd_valid),
      .fifo_empty   (fifo_empty),
      .rd_underflow (rd_underflow),
      .rd_state     (rd_state)
   );

   function automatic logic [PTRW:0] enc(input int v);
      logic [PTRW:0] b;
      b = v[PTRW:0];
`ifdef AIB_RXFIFO_RD_GRAY_EN
      return b ^ (b >> 1);
`else
      return b;
`endif
   endfunction

   assign wr_ptr_sync = enc(wr_cnt);

   function automatic int fill_now();
      return (wr_cnt - m_reads) & (PMOD - 1);
   endfunction

   function automatic logic [DEPTH4-1:0] lane_mask(input int md, input logic g2, input int entry);
      int n;
      n = (md == 0) ? 1 : (md == 1) ? 2 : (g2 ? 4 : 2);
      return ((64'h1 << n) - 64'h1) << (4 * entry);
   endfunction

   function automatic bit m_pop();
      return (m_phase == 2) && rd_req && (fill_now() > 0) && (r_fifo_mode != 2'd3);
   endfunction

   function automatic bit m_regrun();
      return (r_fifo_mode == 2'd3) && (m_phase != 1);
   endfunction

   // Reference model: counts words read since start, phase by fill level.
   always @(posedge clk or posedge rst) begin
      if (rst || !rd_start) begin
         m_phase <= 0;
         m_reads <= 0;
         m_en    <= '0;
         m_v1    <= 1'b0;
         m_valid <= 1'b0;
         m_uf    <= 1'b0;
      end else begin
         m_valid <= m_v1;
         m_v1    <= m_pop() || m_regrun();
         m_en    <= m_pop() ? lane_mask(int'(r_fifo_mode), m_gen2_mode, m_reads % DEPTH)
                  : m_regrun() ? 64'hF : '0;
         if (m_pop()) m_reads <= m_reads + 1;
         if ((m_phase == 2) && rd_req && (fill_now() == 0) && (r_fifo_mode != 2'd3)) m_uf <= 1'b1;
         if (m_phase == 0) m_phase <= (r_fifo_mode == 2'd3) ? 2 : 1;
         else if ((m_phase == 1) && (fill_now() >= int'(r_rd_wm))) m_phase <= 2;
      end
   end

   function automatic logic [VW-1:0] exp_vec();
      return {m_en, enc(m_reads), m_valid, (fill_now() == 0), m_uf, 2'(m_phase)};
   endfunction

   function automatic logic [VW-1:0] obs_vec();
      return {fifo_rd_en, rd_ptr, rd_valid, fifo_empty, rd_underflow, rd_state};
   endfunction

   task automatic restart(input logic [1:0] md, input logic g2, input int wm, input int wr);
      @(negedge clk);
      rd_start = 1'b0;
      rd_req   = 1'b0;
      @(negedge clk);
      r_fifo_mode = md;
      m_gen2_mode = g2;
      r_rd_wm     = wm[PTRW:0];
      wr_cnt      = wr;
      rd_start    = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      nchk++;
      if (fifo_rd_en !== '0 || rd_ptr !== '0 || rd_valid !== 1'b0 || rd_underflow !== 1'b0 ||
          rd_state !== 2'd0 || fifo_empty !== 1'b1) begin
         nerr++;
         $display("FAIL reset: got en=%h ptr=%h v=%b uf=%b st=%0d empty=%b, want all 0 and empty=1",
                  fifo_rd_en, rd_ptr, rd_valid, rd_underflow, rd_state, fifo_empty);
      end
      nchk++;
      if (obs_vec() !== exp_vec()) begin
         nerr++;
         $display("FAIL reset_model: got %h want %h", obs_vec(), exp_vec());
      end
      rst = 1'b0;
   endtask

   task automatic test_fill_start();
      @(negedge clk);
      r_fifo_mode = 2'd0;
      m_gen2_mode = 1'b0;
      r_rd_wm     = 5'd3;
      wr_cnt      = 0;
      rd_start    = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         nchk++;
         if (rd_state !== 2'd1) begin
            nerr++;
            $display("FAIL fill_state: got %0d want 1 (lvl=%0d)", rd_state, k - 1);
         end
         nchk++;
         if (obs_vec() !== exp_vec()) begin
            nerr++;
            $display("FAIL fill_model: got %h want %h", obs_vec(), exp_vec());
         end
         wr_cnt = k;
      end
      @(negedge clk);
      nchk++;
      if (rd_state !== 2'd2) begin
         nerr++;
         $display("FAIL fill_to_run: got %0d want 2", rd_state);
      end
      rd_req = 1'b1;
      @(negedge clk);
      rd_req = 1'b0;
      nchk++;
      if (fifo_rd_en !== 64'h1 || rd_valid !== 1'b0 || rd_ptr !== enc(1)) begin
         nerr++;
         $display("FAIL pop_c1: got en=%h v=%b ptr=%h want en=1 v=0 ptr=%h", fifo_rd_en, rd_valid, rd_ptr, enc(1));
      end
      @(negedge clk);
      nchk++;
      if (rd_valid !== 1'b1 || fifo_rd_en !== '0) begin
         nerr++;
         $display("FAIL pop_c2: got v=%b en=%h want v=1 en=0", rd_valid, fifo_rd_en);
      end
      nchk++;
      if (obs_vec() !== exp_vec()) begin
         nerr++;
         $display("FAIL pop_model: got %h want %h", obs_vec(), exp_vec());
      end
   endtask

   task automatic test_4x_walk();
      restart(2'd2, 1'b1, 0, 3);
      repeat (2) begin
         @(negedge clk);
         nchk++;
         if (obs_vec() !== exp_vec()) begin
            nerr++;
            $display("FAIL walk_start: got %h want %h", obs_vec(), exp_vec());
         end
      end
      rd_req = 1'b1;
      wr_cnt++;
      for (int k = 0; k <= 20; k++) begin
         @(negedge clk);
         nchk++;
         if (obs_vec() !== exp_vec()) begin
            nerr++;
            $display("FAIL walk_model k=%0d: got %h want %h", k, obs_vec(), exp_vec());
         end
         if (k <= 19) begin
            nchk++;
            if (fifo_rd_en !== (64'hF << (4 * (k % DEPTH))) || rd_ptr !== enc(k + 1)) begin
               nerr++;
               $display("FAIL walk_lane k=%0d: got en=%h ptr=%h want en=%h ptr=%h",
                        k, fifo_rd_en, rd_ptr, 64'hF << (4 * (k % DEPTH)), enc(k + 1));
            end
         end
         if (k >= 1) begin
            nchk++;
            if (rd_valid !== 1'b1) begin
               nerr++;
               $display("FAIL walk_bubble k=%0d: got valid=%b want 1", k, rd_valid);
            end
         end
         wr_cnt++;
         if (k == 19) rd_req = 1'b0;
      end
   endtask

   task automatic test_4x_gen1();
      restart(2'd2, 1'b0, 0, 8);
      repeat (2) @(negedge clk);
      rd_req = 1'b1;
      for (int k = 0; k <= 2; k++) begin
         @(negedge clk);
         nchk++;
         if (fifo_rd_en !== (64'h3 << (4 * k))) begin
            nerr++;
            $display("FAIL gen1_lane k=%0d: got %h want %h", k, fifo_rd_en, 64'h3 << (4 * k));
         end
         nchk++;
         if (obs_vec() !== exp_vec()) begin
            nerr++;
            $display("FAIL gen1_model k=%0d: got %h want %h", k, obs_vec(), exp_vec());
         end
         if (k == 2) begin
            rd_req = 1'b0;
            nchk++;
            if (fifo_rd_en !== 64'h300) begin
               nerr++;
               $display("FAIL gen1_entry2: got %h want 300", fifo_rd_en);
            end
         end
      end
   endtask

   task automatic test_underflow();
      restart(2'd0, 1'b0, 1, 33);
      repeat (2) @(negedge clk);
      rd_req = 1'b1;
      for (int k = 0; k <= 2; k++) begin
         @(negedge clk);
         nchk++;
         if (obs_vec() !== exp_vec()) begin
            nerr++;
            $display("FAIL uf_model k=%0d: got %h want %h", k, obs_vec(), exp_vec());
         end
      end
      rd_req = 1'b0;
      nchk++;
      if (rd_underflow !== 1'b1 || rd_ptr !== enc(1) || rd_state !== 2'd2) begin
         nerr++;
         $display("FAIL uf_sticky: got uf=%b ptr=%h st=%0d want uf=1 ptr=%h st=2",
                  rd_underflow, rd_ptr, rd_state, enc(1));
      end
      rd_start = 1'b0;
      @(negedge clk);
      nchk++;
      if (rd_underflow !== 1'b0 || rd_state !== 2'd0 || rd_ptr !== '0) begin
         nerr++;
         $display("FAIL uf_clear: got uf=%b st=%0d ptr=%h want 0 0 0", rd_underflow, rd_state, rd_ptr);
      end
   endtask

`ifdef AIB_RXFIFO_RD_GRAY_EN
   task automatic test_gray();
      int gseq [8];
      logic [PTRW:0] prev;
      gseq = '{0, 1, 3, 2, 6, 7, 5, 4};
      restart(2'd0, 1'b0, 0, 10);
      repeat (2) @(negedge clk);
      nchk++;
      if (rd_ptr !== 5'd0) begin
         nerr++;
         $display("FAIL gray_start: got %h want 0", rd_ptr);
      end
      prev = rd_ptr;
      rd_req = 1'b1;
      for (int k = 0; k <= 7; k++) begin
         @(negedge clk);
         if (k < 7) begin
            nchk++;
            if (rd_ptr !== gseq[k+1][PTRW:0]) begin
               nerr++;
               $display("FAIL gray_seq k=%0d: got %h want %h", k, rd_ptr, gseq[k+1][PTRW:0]);
            end
         end
         nchk++;
         if ($countones(rd_ptr ^ prev) != 1) begin
            nerr++;
            $display("FAIL gray_onebit k=%0d: got %h after %h, want one bit change", k, rd_ptr, prev);
         end
         prev = rd_ptr;
         if (k == 7) rd_req = 1'b0;
      end
   endtask
`endif

   task automatic test_random();
      for (int s = 0; s < 4; s++) begin
         restart(2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 8)), int'($urandom_range(0, 6)));
         for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            nchk++;
            if (obs_vec() !== exp_vec()) begin
               nerr++;
               $display("FAIL random s=%0d c=%0d: got %h want %h", s, c, obs_vec(), exp_vec());
            end
            rd_req = 1'($urandom_range(0, 1));
            if (fill_now() < DEPTH - 1 && $urandom_range(0, 1) == 1) wr_cnt++;
         end
      end
   endtask

   task automatic test_regmode();
      restart(2'd3, 1'b0, 0, 0);
      rd_req = 1'b1;
      @(negedge clk);
      nchk++;
      if (fifo_rd_en !== 64'hF || rd_ptr !== '0 || rd_valid !== 1'b0 || rd_state !== 2'd2) begin
         nerr++;
         $display("FAIL reg_first: got en=%h ptr=%h v=%b st=%0d want F 0 0 2",
                  fifo_rd_en, rd_ptr, rd_valid, rd_state);
      end
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         nchk++;
         if (fifo_rd_en !== 64'hF || rd_ptr !== '0 || rd_valid !== 1'b1 || rd_underflow !== 1'b0) begin
            nerr++;
            $display("FAIL reg_steady k=%0d: got en=%h ptr=%h v=%b uf=%b want F 0 1 0",
                     k, fifo_rd_en, rd_ptr, rd_valid, rd_underflow);
         end
         nchk++;
         if (obs_vec() !== exp_vec()) begin
            nerr++;
            $display("FAIL reg_model k=%0d: got %h want %h", k, obs_vec(), exp_vec());
         end
      end
      #2 rst = 1'b1;
      #1;
      nchk++;
      if (fifo_rd_en !== '0 || rd_ptr !== '0 || rd_valid !== 1'b0 || rd_underflow !== 1'b0 ||
          rd_state !== 2'd0 || fifo_empty !== 1'b1) begin
         nerr++;
         $display("FAIL async_reset: got en=%h ptr=%h v=%b uf=%b st=%0d empty=%b want 0s, empty=1",
                  fifo_rd_en, rd_ptr, rd_valid, rd_underflow, rd_state, fifo_empty);
      end
      @(negedge clk);
      rd_req   = 1'b0;
      rd_start = 1'b0;
      rst      = 1'b0;
   endtask

   initial begin
      nchk        = 0;
      nerr        = 0;
      wr_cnt      = 0;
      rst         = 1'b1;
      rd_start    = 1'b0;
      r_fifo_mode = 2'd0;
      m_gen2_mode = 1'b0;
      r_rd_wm     = '0;
      rd_req      = 1'b0;
      test_reset();
      test_fill_start();
      test_4x_walk();
      test_4x_gen1();
      test_underflow();
`ifdef AIB_RXFIFO_RD_GRAY_EN
      test_gray();
`endif
      test_random();
      test_regmode();
      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule

// File: doc/aib_rxfifo_rd_ctrl.md
Name: aib_rxfifo_rd_ctrl

Overview:
Read-side controller for the AIB RX adapter FIFO. Owns the read pointer, phase-compensation watermark start-up and empty/underflow detection. Drives the one-hot, per-80-bit-lane fifo_rd_en vector consumed by the RX FIFO read datapath, according to FIFO mode and Gen2 mode. Sits in the rd_clk domain, next to the read datapath; the write pointer arrives already synchronised.

Parameters:
DEPTH, 16, number of FIFO entries; must be a power of 2, minimum 2.
DEPTH4, DEPTH*4, number of 80-bit lanes (4 per entry); derived, not overridden.
PTRW, $clog2(DEPTH), entry index width; pointers carry one extra wrap bit.

Ports:
rd_clk  in  1  FIFO read clock.
rd_rst  in  1  Asynchronous, active-high reset.
rd_start  in  1  Channel read enable; low forces IDLE.
r_fifo_mode  in  2  00 = 1:1, 01 = 2:1, 10 = 4:1, 11 = register mode.
m_gen2_mode  in  1  Gen2 mode; 4:1 is legal only when this is 1.
r_rd_wm  in  PTRW+1  Fill-level watermark required before reads start.
rd_req  in  1  Consumer pop request.
wr_ptr_sync  in  PTRW+1  Binary write pointer, with wrap bit, synchronised to rd_clk.
fifo_rd_en  out  DEPTH4  Lane select; bit 4k+j selects lane j of entry k.
rd_ptr  out  PTRW+1  Read pointer, with wrap bit, sent to the write-side full logic.
rd_valid  out  1  Read data is valid this cycle.
fifo_empty  out  1  Fill level is 0.
rd_underflow  out  1  Sticky underflow flag.
rd_state  out  2  FSM state, for debug.

Behaviour:
- Reset (rd_rst high, asynchronous). All outputs are 0, except fifo_empty = 1. rd_state = IDLE.
- Fill level: lvl = (wr_ptr_sync - rd_ptr) mod 2^(PTRW+1). fifo_empty = (lvl == 0), combinational.
- Lane mask per mode:
  - 00: lane 0.
  - 01: lanes 0–1.
  - 10: lanes 0–3 if m_gen2_mode = 1; otherwise lanes 0–1.
- FSM states: IDLE = 0, FILL = 1, RUN = 2.
  - IDLE -> FILL when rd_start = 1 and mode != 11.
  - IDLE -> RUN when rd_start = 1 and mode == 11.
  - FILL -> RUN when lvl >= r_rd_wm. r_rd_wm = 0 gives a direct transition on the next cycle.
  - Any state -> IDLE when rd_start = 0. Entering IDLE clears rd_ptr, fifo_rd_en, the rd_valid pipeline and rd_underflow.
- Pop (combinational): pop = (state == RUN) & rd_req & !fifo_empty & (mode != 11).
- Latency, with pop true in cycle c:
  - rd_ptr increments at the end of cycle c (wraps naturally modulo 2^(PTRW+1)).
  - fifo_rd_en is registered and, during cycle c+1, carries the lane mask of the popped entry.
  - rd_valid is high during cycle c+2, aligned with the registered datapath output.
  - With no pop, fifo_rd_en = 0 in the following cycle.
- Back-to-back pops: sustained one per cycle while not empty.
- Simultaneous write and last-entry pop: empty status uses the current wr_ptr_sync value only; no look-ahead.
- Underflow:
  - rd_req = 1 in RUN with fifo_empty = 1 sets rd_underflow, sticky until rd_rst or rd_start = 0.
  - rd_ptr does not move.
  - FSM stays in RUN.
- Register mode (11) in RUN:
  - fifo_rd_en[3:0] = 4'hF continuously; all other bits are 0.
  - rd_ptr is held at 0.
  - rd_valid = 1 from the second RUN cycle onward.
  - No underflow detection.
- A mode change while not in IDLE is unsupported; software must drop rd_start first.

Optional Feature:
AIB_RXFIFO_RD_GRAY_EN
- Defined: rd_ptr is driven Gray-coded from a dedicated register, glitch-free, for direct CDC into the write domain. wr_ptr_sync is interpreted as Gray and converted to binary internally before the fill-level computation.
- Undefined: both pointers are binary, and the caller handles encoding.

Decomposition:
- Package aib_rxfifo_rd_pkg:
  - FIFO mode enum: FIFO_1X = 2'b00, FIFO_2X = 2'b01, FIFO_4X = 2'b10, FIFO_REG = 2'b11.
  - rd_state enum: IDLE, FILL, RUN.
  - LANES_PER_ENTRY = 4.
  - bin2gray and gray2bin functions.
- One sub-module: aib_rxfifo_rd_lanesel. It is combinational and maps (entry index, mode, gen2, pop) to the DEPTH4 lane mask, registered in the parent.

Test Plan:
1. Reset, then rd_start = 1, mode 00, r_rd_wm = 3, wr_ptr_sync stepping 0→3 -> FILL until lvl = 3, then RUN. A pop gives fifo_rd_en = 0x1 one cycle later and rd_valid two cycles later.
2. Mode 10, m_gen2_mode = 1, DEPTH = 16, 20 consecutive pops with the FIFO kept non-empty -> fifo_rd_en walks 0xF << 4k. rd_ptr wraps 15→0 with the wrap bit toggling, and no bubble.
3. Mode 10, m_gen2_mode = 0 -> popping entry 2 gives fifo_rd_en = 0x300.
4. RUN with lvl = 1, rd_req held for 3 cycles -> one pop, then rd_underflow = 1 and rd_ptr frozen. Dropping rd_start clears the flag and returns the FSM to IDLE.
5. Mode 11 -> fifo_rd_en = 0xF, rd_ptr = 0 and rd_valid = 1 steady. Asserting rd_rst mid-run gives all outputs 0 immediately (asynchronously).
6. With AIB_RXFIFO_RD_GRAY_EN defined, 8 pops -> rd_ptr follows the Gray sequence 0,1,3,2,6,7,5,4, changing exactly one bit per pop.
